// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: decodes the IR opcode/rt
// and sequences fetch, decode, execute, memory and write-back each cycle.
module multicycle_control (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [4:0] rt,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic       BranchType,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [3:0] ALUOp,
  output logic       illegal,
  output logic [3:0] state
);

  localparam logic [3:0] FETCH    = 4'd0;
  localparam logic [3:0] DECODE   = 4'd1;
  localparam logic [3:0] MEMADDR  = 4'd2;
  localparam logic [3:0] MEMREAD  = 4'd3;
  localparam logic [3:0] MEMWB    = 4'd4;
  localparam logic [3:0] MEMWRITE = 4'd5;
  localparam logic [3:0] EXEC_R   = 4'd6;
  localparam logic [3:0] RWB      = 4'd7;
  localparam logic [3:0] BRANCH   = 4'd8;
  localparam logic [3:0] JUMP     = 4'd9;
  localparam logic [3:0] EXEC_I   = 4'd10;
  localparam logic [3:0] IWB      = 4'd11;

  localparam logic [5:0] OP_RTYPE  = 6'd0;
  localparam logic [5:0] OP_REGIMM = 6'd1;
  localparam logic [5:0] OP_J      = 6'd2;
  localparam logic [5:0] OP_BEQ    = 6'd4;
  localparam logic [5:0] OP_ADDI   = 6'd8;
  localparam logic [5:0] OP_ADDIU  = 6'd9;
  localparam logic [5:0] OP_ANDI   = 6'd12;
  localparam logic [5:0] OP_ORI    = 6'd13;
  localparam logic [5:0] OP_XORI   = 6'd14;
  localparam logic [5:0] OP_LUI    = 6'd15;
  localparam logic [5:0] OP_LW     = 6'd35;
  localparam logic [5:0] OP_SW     = 6'd43;

  localparam logic [4:0] RT_BGEZ   = 5'd1;
  localparam logic [4:0] RT_BGEZAL = 5'd17;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_FUNCT = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_AND   = 4'd6;
  localparam logic [3:0] ALU_BGEZ  = 4'd7;
  localparam logic [3:0] ALU_ADDU  = 4'd8;
  localparam logic [3:0] ALU_LUI   = 4'd9;

  logic [3:0] state_q;
  logic [3:0] state_d;

  logic dec_mem;
  logic dec_sw;
  logic dec_rtype;
  logic dec_beq;
  logic dec_regimm_br;
  logic dec_bgezal;
  logic dec_jump;
  logic dec_itype;
  logic [3:0] itype_aluop;

  // Opcode decode; opcode/rt are stable from DECODE through write-back.
  always_comb begin
    dec_mem       = (opcode == OP_LW) || (opcode == OP_SW);
    dec_sw        = (opcode == OP_SW);
    dec_rtype     = (opcode == OP_RTYPE);
    dec_beq       = (opcode == OP_BEQ);
    dec_regimm_br = (opcode == OP_REGIMM) && ((rt == RT_BGEZ) || (rt == RT_BGEZAL));
    dec_bgezal    = (opcode == OP_REGIMM) && (rt == RT_BGEZAL);
    dec_jump      = (opcode == OP_J);
    dec_itype     = (opcode == OP_ADDI) || (opcode == OP_ADDIU) ||
                    (opcode == OP_ANDI) || (opcode == OP_ORI)   ||
                    (opcode == OP_XORI) || (opcode == OP_LUI);
  end

  always_comb begin
    itype_aluop = ALU_ADD;
    case (opcode)
      OP_ADDI:  itype_aluop = ALU_ADD;
      OP_ADDIU: itype_aluop = ALU_ADDU;
      OP_ANDI:  itype_aluop = ALU_AND;
      OP_ORI:   itype_aluop = ALU_OR;
      OP_XORI:  itype_aluop = ALU_XOR;
      OP_LUI:   itype_aluop = ALU_LUI;
      default:  itype_aluop = ALU_ADD;
    endcase
  end

  // Memory handshake: an access presented in FETCH/MEMREAD/MEMWRITE completes
  // in the cycle mem_ready is 1; until then the state and the access strobes
  // hold unchanged. mem_ready is don't-care in every other state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:    state_d = mem_ready ? DECODE : FETCH;
      DECODE: begin
        if (dec_mem)            state_d = MEMADDR;
        else if (dec_rtype)     state_d = EXEC_R;
        else if (dec_beq)       state_d = BRANCH;
        else if (dec_regimm_br) state_d = BRANCH;
        else if (dec_jump)      state_d = JUMP;
        else if (dec_itype)     state_d = EXEC_I;
        else                    state_d = FETCH;
      end
      MEMADDR:  state_d = dec_sw ? MEMWRITE : MEMREAD;
      MEMREAD:  state_d = mem_ready ? MEMWB : MEMREAD;
      MEMWB:    state_d = FETCH;
      MEMWRITE: state_d = mem_ready ? FETCH : MEMWRITE;
      EXEC_R:   state_d = RWB;
      RWB:      state_d = FETCH;
      BRANCH:   state_d = FETCH;
      JUMP:     state_d = FETCH;
      EXEC_I:   state_d = IWB;
      IWB:      state_d = FETCH;
      default:  state_d = FETCH;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  // Reset masks every output so an aborted instruction cannot issue a write.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    BranchType  = 1'b0;
    RegDst      = 2'd0;
    MemtoReg    = 2'd0;
    ALUSrcB     = 2'd0;
    PCSource    = 2'd0;
    ALUOp       = ALU_ADD;
    illegal     = 1'b0;
    state       = FETCH;
    if (!reset) begin
      state = state_q;
      case (state_q)
        FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'd1;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        DECODE: begin
          ALUSrcB = 2'd3;
          illegal = !(dec_mem || dec_rtype || dec_beq || dec_regimm_br ||
                      dec_jump || dec_itype);
        end
        MEMADDR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'd2;
        end
        MEMREAD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        MEMWB: begin
          RegWrite = 1'b1;
          MemtoReg = 2'd1;
        end
        MEMWRITE: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
        end
        EXEC_R: begin
          ALUSrcA = 1'b1;
          ALUOp   = ALU_FUNCT;
        end
        RWB: begin
          RegWrite = 1'b1;
          RegDst   = 2'd1;
        end
        BRANCH: begin
          ALUSrcA     = 1'b1;
          PCWriteCond = 1'b1;
          PCSource    = 2'd1;
          if (dec_beq) begin
            ALUOp = ALU_SUB;
          end else begin
            ALUOp      = ALU_BGEZ;
            BranchType = 1'b1;
          end
          // Link is unconditional: PC already holds PC+4 here.
          if (dec_bgezal) begin
            RegWrite = 1'b1;
            RegDst   = 2'd2;
            MemtoReg = 2'd2;
          end
        end
        JUMP: begin
          PCWrite  = 1'b1;
          PCSource = 2'd2;
        end
        EXEC_I: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'd2;
          ALUOp   = itype_aluop;
        end
        IWB: begin
          RegWrite = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
